// File: rtl/sum_feeder_pkg.sv
// Shared types and the LFSR step used by the sum-accumulator stimulus feeder.
package sum_feeder_pkg;

  typedef enum logic [2:0] {IDLE, SEND, TERM, WAIT, CHECK} state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // 8-bit Galois LFSR, right shift; never reaches zero from a non-zero seed.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/sum_feeder_if.sv
// Handshake between the feeder (master) and the accumulator/downstream pair (slave).
interface sum_feeder_if #(
  parameter int W = 8
);
  logic         go_l;
  logic [W-1:0] value_out;
  logic         done;
  logic [W-1:0] dut_result;

  modport master (output go_l, output value_out, input done, input dut_result);
  modport slave  (input go_l, input value_out, output done, output dut_result);
endinterface

// File: rtl/sum_feeder_btn_sync_edge.sv
// Two-flop synchronizer for an active-low pushbutton plus a one-cycle press pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_l,
  input  logic i_btn_l,
  output logic o_fall_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Reset to the released level so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_btn_l;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_fall_pulse = r_prev & ~r_sync2;

endmodule

// File: rtl/sum_feeder.sv
// Streams a pseudo-random non-zero run plus zero terminator to the accumulator,
// then checks the downstream result against its own running sum.
module sum_feeder
  import sum_feeder_pkg::*;
#(
  parameter int         W        = 8,
  parameter int         NUM_VALS = 4,
  parameter logic [7:0] SEED     = 8'hA5,
  parameter int         TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         i_start_btn_l,
  sum_feeder_if.master bus,
  output logic [W-1:0] o_exp_sum,
  output logic         o_match,
  output logic         o_timeout,
  output logic         o_busy
);

  localparam int CW = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  state_t        r_state;
  logic [7:0]    r_lfsr;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic [W-1:0]  r_exp_sum;
  logic [W-1:0]  r_value;
  logic          r_go_l;
  logic          r_match;
  logic          r_timeout;
  logic          r_busy;

  logic          w_start_pulse;
  logic [TW-1:0] w_timer_nxt;

  btn_sync_edge u_btn (
    .clk          (clk),
    .rst_l        (rst_l),
    .i_btn_l      (i_start_btn_l),
    .o_fall_pulse (w_start_pulse)
  );

  // Timer counts WAIT cycles including the current one, so the run gives up
  // after exactly TIMEOUT cycles of waiting.
  assign w_timer_nxt = r_timer + TW'(1);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= IDLE;
      r_lfsr    <= SEED;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_exp_sum <= '0;
      r_value   <= '0;
      r_go_l    <= 1'b1;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_pulse) begin
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
            r_exp_sum <= '0;
            r_cnt     <= '0;
            r_go_l    <= 1'b0;
            r_value   <= W'(r_lfsr);
            r_busy    <= 1'b1;
            r_state   <= SEND;
          end
        end
        SEND: begin
          r_exp_sum <= r_exp_sum + W'(r_lfsr);
          r_lfsr    <= lfsr_next(r_lfsr);
          r_cnt     <= r_cnt + CW'(1);
          r_go_l    <= 1'b1;
          if (r_cnt == CW'(NUM_VALS - 1)) begin
            r_value <= '0;
            r_state <= TERM;
          end else begin
            r_value <= W'(lfsr_next(r_lfsr));
          end
        end
        TERM: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= w_timer_nxt;
          if (bus.done) begin
            r_state <= CHECK;
          end else if (w_timer_nxt == TW'(TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_match   <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        CHECK: begin
          r_match <= (bus.dut_result == r_exp_sum);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_go_l  <= 1'b1;
          r_value <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.go_l      = r_go_l;
  assign bus.value_out = r_value;
  assign o_exp_sum     = r_exp_sum;
  assign o_match       = r_match;
  assign o_timeout     = r_timeout;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_sum_feeder.sv
// Randomized and directed bench for sum_feeder against a run-level reference model.
module tb_sum_feeder;

  localparam int         W        = 8;
  localparam int         NUM_VALS = 4;
  localparam int         TIMEOUT  = 255;
  localparam logic [7:0] SEED     = 8'hA5;

  logic         clk   = 1'b0;
  logic         rst_l = 1'b0;
  logic         btn_l = 1'b1;
  logic [W-1:0] exp_sum;
  logic         match;
  logic         timeout;
  logic         busy;

  sum_feeder_if #(.W(W)) bus ();

  sum_feeder #(
    .W(W), .NUM_VALS(NUM_VALS), .SEED(SEED), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .i_start_btn_l (btn_l),
    .bus           (bus),
    .o_exp_sum     (exp_sum),
    .o_match       (match),
    .o_timeout     (timeout),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int         errors  = 0;
  int         checks  = 0;
  int         cyc     = 0;
  int         rel_cyc = -1;
  logic [7:0] m_lfsr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference LFSR: halve, and fold in the tap pattern when a one falls out.
  function automatic logic [7:0] model_lfsr(input logic [7:0] l);
    if (l % 2 == 1) return (l / 2) ^ 8'hB8;
    return l / 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == rel_cyc) btn_l = 1'b1;
  endtask

  task automatic press(input int hold);
    btn_l   = 1'b0;
    rel_cyc = cyc + hold;
  endtask

  // done_dly: cycles after TERM that done pulses (<0: never). junk_k: SEND index
  // at which a stray done and a second button press are injected (<0: none).
  task automatic do_run(input string nm, input int done_dly, input bit bad, input int junk_k);
    logic [7:0] vals [NUM_VALS];
    int sum;
    int n;
    sum = 0;
    for (int k = 0; k < NUM_VALS; k++) begin
      vals[k] = m_lfsr;
      sum     = (sum + int'(m_lfsr)) % 256;
      m_lfsr  = model_lfsr(m_lfsr);
    end
    n = 0;
    while (bus.go_l === 1'b1 && n < 10) begin
      step();
      n++;
    end
    check_eq({nm, ".go_fall"}, bus.go_l, 0);
    if (bus.go_l !== 1'b0) return;
    check_eq({nm, ".match_clr"}, match, 0);
    check_eq({nm, ".tmo_clr"}, timeout, 0);
    for (int k = 0; k < NUM_VALS; k++) begin
      check_eq({nm, ".value"}, bus.value_out, vals[k]);
      check_eq({nm, ".go_l"}, bus.go_l, (k == 0) ? 0 : 1);
      check_eq({nm, ".busy"}, busy, 1);
      if (k == junk_k) begin
        bus.done = 1'b1;
        btn_l    = 1'b0;
        rel_cyc  = cyc + 2;
      end
      step();
      bus.done = 1'b0;
    end
    check_eq({nm, ".term_val"}, bus.value_out, 0);
    check_eq({nm, ".term_go"}, bus.go_l, 1);
    check_eq({nm, ".exp_sum"}, exp_sum, sum);
    step();
    if (done_dly < 0) begin
      for (int w = 0; w < TIMEOUT; w++) begin
        if (w == TIMEOUT - 1) begin
          check_eq({nm, ".tmo_early"}, timeout, 0);
          check_eq({nm, ".busy_wait"}, busy, 1);
        end
        step();
      end
      check_eq({nm, ".tmo_set"}, timeout, 1);
      check_eq({nm, ".tmo_idle"}, busy, 0);
      check_eq({nm, ".tmo_match"}, match, 0);
    end else begin
      for (int w = 0; w < done_dly - 1; w++) step();
      check_eq({nm, ".busy_wait"}, busy, 1);
      check_eq({nm, ".wait_val"}, bus.value_out, 0);
      bus.done = 1'b1;
      step();
      bus.done       = 1'b0;
      bus.dut_result = bad ? W'(sum + 1) : W'(sum);
      step();
      check_eq({nm, ".match"}, match, bad ? 0 : 1);
      check_eq({nm, ".timeout"}, timeout, 0);
      check_eq({nm, ".busy_end"}, busy, 0);
    end
  endtask

  // Waits for the button to be released and confirms no further run starts.
  task automatic settle(input string nm);
    logic saw;
    saw = 1'b0;
    for (int i = 0; i < 80 && btn_l === 1'b0; i++) begin
      step();
      saw = saw | busy;
    end
    for (int i = 0; i < 6; i++) begin
      step();
      saw = saw | busy;
    end
    check_eq({nm, ".no_retrig"}, saw, 0);
  endtask

  initial begin
    int n;
    int hold;
    int dly;
    bit bad;
    bus.done       = 1'b0;
    bus.dut_result = '0;
    m_lfsr         = SEED;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.go_l", bus.go_l, 1);
    check_eq("rst.value", bus.value_out, 0);
    check_eq("rst.exp_sum", exp_sum, 0);
    check_eq("rst.match", match, 0);
    check_eq("rst.timeout", timeout, 0);
    check_eq("rst.busy", busy, 0);
    rst_l = 1'b1;
    step();

    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    check_eq("idle_done.busy", busy, 0);

    press(3);
    do_run("run1", 3, 1'b0, -1);
    settle("run1");
    check_eq("run1.match_hold", match, 1);

    press(3);
    do_run("run2", 3, 1'b1, -1);
    settle("run2");

    press(3);
    do_run("tmo", -1, 1'b0, -1);
    settle("tmo");
    check_eq("tmo.hold", timeout, 1);

    press(3);
    do_run("edge_done", TIMEOUT, 1'b0, -1);
    settle("edge_done");

    press(50);
    do_run("held", 3, 1'b0, -1);
    settle("held");

    press(2);
    do_run("repress", 3, 1'b0, 1);
    settle("repress");

    press(3);
    n = 0;
    while (bus.go_l === 1'b1 && n < 10) begin
      step();
      n++;
    end
    check_eq("rst_mid.go_fall", bus.go_l, 0);
    step();
    step();
    rst_l = 1'b0;
    #1;
    check_eq("rst_mid.go_l", bus.go_l, 1);
    check_eq("rst_mid.value", bus.value_out, 0);
    check_eq("rst_mid.busy", busy, 0);
    check_eq("rst_mid.exp_sum", exp_sum, 0);
    m_lfsr = SEED;
    step();
    btn_l   = 1'b1;
    rel_cyc = -1;
    rst_l   = 1'b1;
    repeat (4) step();
    check_eq("rst_mid.idle", busy, 0);
    press(3);
    do_run("after_rst", 3, 1'b0, -1);
    settle("after_rst");

    #2 btn_l = 1'b0;
    #2 btn_l = 1'b1;
    repeat (6) step();
    check_eq("glitch_short.busy", busy, 0);
    #5 btn_l = 1'b0;
    step();
    btn_l = 1'b1;
    check_eq("glitch.no_x", {31'd0, $isunknown(bus.go_l)}, 0);
    do_run("glitch", 2, 1'b0, -1);
    settle("glitch");

    for (int r = 0; r < 8; r++) begin
      hold = $urandom_range(1, 20);
      dly  = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, 12);
      bad  = 1'($urandom_range(0, 1));
      press(hold);
      do_run("rnd", dly, bad, -1);
      settle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
